// File: rtl/lanzones_pkg.sv
// Shared decode constants, FSM state encoding and immediate helpers for the
// lanzones multi-cycle RV32I-subset core.
package lanzones_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FWAIT,
        EXEC,
        LREQ,
        LWAIT
    } state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    // Byte address to word address; the low two bits are simply dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/lanzones_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port, x0 reads as zero and ignores writes.
module lanzones_regfile
    import lanzones_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [0:31];

    // Whole array clears on reset, so this stays in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/lanzones.sv
// Multi-cycle core executing LW/ADDI/ADD/LUI (everything else is a NOP) over a
// single shared word-addressed read port to a synchronous ROM.
module lanzones
    import lanzones_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        LEn,
    output logic        RRdy,
    output logic [31:0] RAddr,
    input  logic        RVld,
    input  logic [31:0] RData
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] raddr_reg, raddr_next;

    logic [31:0] rs1_data, rs2_data;
    logic        we;
    logic [31:0] wd;
    logic        retire;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_lw, is_addi, is_add, is_lui;

    assign opcode  = ir_reg[6:0];
    assign funct3  = ir_reg[14:12];
    assign funct7  = ir_reg[31:25];
    assign is_lw   = (opcode == OP_LOAD) && (funct3 == F3_LW);
    assign is_addi = (opcode == OP_IMM)  && (funct3 == F3_ADDI);
    assign is_add  = (opcode == OP_REG)  && (funct3 == F3_ADD) && (funct7 == F7_ADD);
    assign is_lui  = (opcode == OP_LUI);

    lanzones_regfile u_regfile (
        .clk  (clk),
        .rstn (rstn),
        .ra1  (ir_reg[19:15]),
        .ra2  (ir_reg[24:20]),
        .rd1  (rs1_data),
        .rd2  (rs2_data),
        .we   (we),
        .wa   (ir_reg[11:7]),
        .wd   (wd)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            raddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            raddr_reg <= raddr_next;
        end
    end

    // RAddr is registered and only reloaded on entry to FETCH/LREQ, which keeps
    // it stable for the whole request/response window.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        raddr_next = raddr_reg;
        RRdy       = 1'b0;
        we         = 1'b0;
        wd         = '0;
        retire     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (LEn) begin
                    state_next = FETCH;
                    raddr_next = word_addr(pc_reg);
                end
            end
            FETCH: begin
                RRdy       = 1'b1;
                state_next = FWAIT;
            end
            FWAIT: begin
                if (RVld) begin
                    ir_next    = RData;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (is_lw) begin
                    raddr_next = word_addr(rs1_data + imm_i(ir_reg));
                    state_next = LREQ;
                end else begin
                    we     = is_addi || is_add || is_lui;
                    retire = 1'b1;
                    if (is_lui) begin
                        wd = imm_u(ir_reg);
                    end else if (is_add) begin
                        wd = rs1_data + rs2_data;
                    end else begin
                        wd = rs1_data + imm_i(ir_reg);
                    end
                end
            end
            LREQ: begin
                RRdy       = 1'b1;
                state_next = LWAIT;
            end
            LWAIT: begin
                if (RVld) begin
                    we     = 1'b1;
                    wd     = RData;
                    retire = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (retire) begin
            pc_next = pc_reg + 32'd4;
            if (LEn) begin
                state_next = FETCH;
                raddr_next = word_addr(pc_reg + 32'd4);
            end else begin
                state_next = IDLE;
            end
        end
    end

    assign RAddr = raddr_reg;

endmodule

// File: tb/tb_lanzones.sv
// Directed bench for lanzones: table of short programs plus hand sequences for
// LEn drop, protocol rules over a long LW run and mid-run reset.
module tb_lanzones;
    import lanzones_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        LEn;
    logic        RRdy;
    logic [31:0] RAddr;
    logic        RVld;
    logic [31:0] RData;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];

    // monitor state
    int          mon_total = 0;
    int          cyc = 0;
    logic [31:0] req_addr [0:63];
    int          req_cyc  [0:63];
    int          b2b_cnt = 0;
    int          unstable_cnt = 0;
    logic        prev_rrdy = 1'b0;
    logic        pending = 1'b0;
    logic [31:0] held = '0;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w4;
        int          limit;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        int          gap;
        int          ra;
        logic [31:0] va;
        int          rb;
        logic [31:0] vb;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [0:NV-1];

    lanzones dut (
        .clk   (clk),
        .rstn  (rstn),
        .LEn   (LEn),
        .RRdy  (RRdy),
        .RAddr (RAddr),
        .RVld  (RVld),
        .RData (RData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        RVld  <= RRdy;
        RData <= mem[RAddr[5:0]];
    end

    always @(negedge clk) begin
        if (RRdy) begin
            req_addr[mon_total % 64] <= RAddr;
            req_cyc[mon_total % 64]  <= cyc;
            mon_total                <= mon_total + 1;
        end
        if (!rstn) begin
            prev_rrdy <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (RRdy && prev_rrdy) b2b_cnt <= b2b_cnt + 1;
            if (pending && !RRdy && (RAddr != held)) unstable_cnt <= unstable_cnt + 1;
            if (RVld) pending <= 1'b0;
            if (RRdy) begin
                pending <= 1'b1;
                held    <= RAddr;
            end
            prev_rrdy <= RRdy;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        LEn  = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_reqs(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (mon_total < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(mon_total >= target), 32'd1);
    endtask

    function automatic int nonzero_regs();
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.u_regfile.regs[i] != 32'd0) nz++;
        end
        return nz;
    endfunction

    function automatic logic [31:0] pick(input vec_t v, input int i);
        if (i == 0) return v.a0;
        if (i == 1) return v.a1;
        return v.a2;
    endfunction

    initial begin
        int base;
        vec_t v;

        vecs[0] = '{32'h01002083, 32'h00000000, 32'hDEADBEEF, 3, 32'd0, 32'd4, 32'd1, 5,
                    1, 32'hDEADBEEF, 0, 32'd0, 32'd8};
        vecs[1] = '{32'h00100113, 32'h002101B3, 32'h00000000, 3, 32'd0, 32'd1, 32'd2, 6,
                    2, 32'd1, 3, 32'd2, 32'd12};
        vecs[2] = '{32'h01002003, 32'h0000007F, 32'hDEADBEEF, 3, 32'd0, 32'd4, 32'd1, 5,
                    0, 32'd0, 0, 32'd0, 32'd8};
        vecs[3] = '{32'h123452B7, 32'h00000000, 32'h00000000, 1, 32'd0, 32'd0, 32'd0, 0,
                    5, 32'h12345000, 0, 32'd0, 32'd4};
        vecs[4] = '{32'hFFF00313, 32'h006303B3, 32'h00000000, 2, 32'd0, 32'd1, 32'd0, 3,
                    6, 32'hFFFFFFFF, 7, 32'hFFFFFFFE, 32'd8};
        vecs[5] = '{32'h01400493, 32'hFFD4A503, 32'hA5A55A5A, 3, 32'd0, 32'd1, 32'd4, 6,
                    9, 32'd20, 10, 32'hA5A55A5A, 32'd8};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state, and no requests while LEn stays low
        do_reset();
        chk("reset_rrdy", 32'(RRdy), 32'd0);
        chk("reset_raddr", RAddr, 32'd0);
        chk("reset_pc", dut.pc_reg, 32'd0);
        chk("reset_ir", dut.ir_reg, 32'd0);
        chk("reset_state", 32'(dut.state_reg), 32'(IDLE));
        chk("reset_regs", 32'(nonzero_regs()), 32'd0);
        base = mon_total;
        repeat (20) @(negedge clk);
        #1;
        chk("len0_no_req", 32'(mon_total - base), 32'd0);
        $display("reset sequence done");

        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[0] = v.w0;
            mem[1] = v.w1;
            mem[4] = v.w4;
            do_reset();
            base = mon_total;
            LEn  = 1'b1;
            wait_reqs(base + v.limit, 40, "vec_req_timeout");
            LEn = 1'b0;
            repeat (10) @(negedge clk);
            #1;
            chk("vec_req_count", 32'(mon_total - base), 32'(v.limit));
            for (int i = 0; i < v.limit; i++) begin
                chk("vec_req_addr", req_addr[(base + i) % 64], pick(v, i));
            end
            chk("vec_gap", 32'(req_cyc[(base + v.limit - 1) % 64] - req_cyc[base % 64]), 32'(v.gap));
            chk("vec_state", 32'(dut.state_reg), 32'(IDLE));
            chk("vec_rrdy", 32'(RRdy), 32'd0);
            chk("vec_pc", dut.pc_reg, v.pc);
            chk("vec_reg_a", dut.u_regfile.regs[v.ra], v.va);
            chk("vec_reg_b", dut.u_regfile.regs[v.rb], v.vb);
            chk("vec_x0", dut.u_regfile.regs[0], 32'd0);
            $display("vector %0d: w0=%h w1=%h reqs=%0d pc=%h", k, v.w0, v.w1, mon_total - base, dut.pc_reg);
        end

        // LEn drops while the load is outstanding
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h01002083;
        mem[4] = 32'hCAFEF00D;
        do_reset();
        base = mon_total;
        LEn  = 1'b1;
        wait_reqs(base + 2, 40, "drop_req_timeout");
        @(negedge clk);
        #1;
        chk("drop_in_lwait", 32'(dut.state_reg), 32'(LWAIT));
        LEn = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("drop_state", 32'(dut.state_reg), 32'(IDLE));
        chk("drop_pc", dut.pc_reg, 32'd4);
        chk("drop_x1", dut.u_regfile.regs[1], 32'hCAFEF00D);
        chk("drop_no_req", 32'(mon_total - base), 32'd2);
        LEn = 1'b1;
        wait_reqs(base + 3, 20, "resume_timeout");
        chk("resume_addr", req_addr[(base + 2) % 64], 32'd1);
        LEn = 1'b0;
        repeat (8) @(negedge clk);
        $display("LEn drop sequence done");

        // Long LW run for protocol rules, then reset mid-run
        for (int i = 0; i < 64; i++) mem[i] = 32'h01002083;
        do_reset();
        base = mon_total;
        LEn  = 1'b1;
        repeat (1000) @(negedge clk);
        #1;
        chk("proto_activity", 32'(mon_total - base >= 390), 32'd1);
        chk("proto_b2b", 32'(b2b_cnt), 32'd0);
        chk("proto_stable", 32'(unstable_cnt), 32'd0);
        chk("proto_x1", dut.u_regfile.regs[1], 32'h01002083);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_state", 32'(dut.state_reg), 32'(IDLE));
        chk("midrst_pc", dut.pc_reg, 32'd0);
        chk("midrst_rrdy", 32'(RRdy), 32'd0);
        chk("midrst_raddr", RAddr, 32'd0);
        chk("midrst_regs", 32'(nonzero_regs()), 32'd0);
        base = mon_total;
        rstn = 1'b1;
        wait_reqs(base + 1, 20, "midrst_timeout");
        chk("midrst_fetch0", req_addr[base % 64], 32'd0);
        repeat (50) @(negedge clk);
        LEn = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("proto_b2b_end", 32'(b2b_cnt), 32'd0);
        chk("proto_stable_end", 32'(unstable_cnt), 32'd0);
        $display("protocol run done: requests=%0d", mon_total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lanzones.md
Name: lanzones

Overview:
- Minimal multi-cycle RV32I-subset core: fetches instructions and performs LW data loads through a single shared word-addressed read port.
- Top-level CPU block sitting directly on a synchronous read-only memory.
- LEn gates execution.
- Supports LW, ADDI, ADD, LUI; all other opcodes execute as NOP.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous active-low reset.
- LEn  in  1  run enable; core leaves IDLE only while high.
- RRdy  out  1  read request strobe, one-cycle pulse per request.
- RAddr  out  32  word address = {2'b00, byte_addr[31:2]}.
- RVld  in  1  read data valid, one-cycle pulse.
- RData  in  32  read data, sampled when RVld=1.

Behaviour:
- Memory contract: RRdy high at edge N produces RVld=1 and RData=mem[RAddr] from edge N+1. Waits tolerate any latency ≥1.
- RRdy is never high in two consecutive cycles.
- RAddr is held stable from request until RVld is received.
- Reset (rstn=0 at clock edge):
  - state=IDLE, PC=RESET_PC, RRdy=0, RAddr=0, IR=0, all 32 registers=0.
  - Reset mid-operation aborts the instruction and discards the pending response.
- States:
  - IDLE: RRdy=0. If LEn=1, go to FETCH.
  - FETCH: RRdy=1, RAddr=PC>>2, go to FWAIT.
  - FWAIT: RRdy=0. On RVld, IR<=RData and go to EXEC.
  - EXEC: decode IR.
    - LW: compute ea=x[rs1]+sext(imm[11:0]), go to LREQ.
    - Else: write rd if the op is supported, PC<=PC+4, then go to FETCH if LEn=1, otherwise IDLE.
  - LREQ: RRdy=1, RAddr=ea>>2, go to LWAIT.
  - LWAIT: on RVld, x[rd]<=RData, PC<=PC+4, then go to FETCH if LEn=1, otherwise IDLE.
- Decode rules:
  - LW: opcode 0000011 with funct3 010.
  - ADDI: opcode 0010011 with funct3 000.
  - ADD: opcode 0110011 with funct3 000 and funct7 0.
  - LUI: opcode 0110111, rd = {imm[31:12], 12'b0}.
- Arithmetic: 32-bit, wrap-around, no overflow flags.
- Register x0 reads 0; writes to x0 are dropped.
- Misaligned ea: low two bits ignored, no trap.
- RVld outside FWAIT/LWAIT is ignored.
- LEn falling mid-instruction: the current instruction completes, then the core goes to IDLE with PC retained. LEn rising resumes fetch at the retained PC.
- Cycle counts from FETCH: non-load instruction 3 cycles, LW 5 cycles (with 1-cycle memory).
- Register file: regs[0:31] x 32 bits, 2 async read ports, 1 sync write port, hierarchically accessible for checking.

Decomposition:
- Package lanzones_pkg holds:
  - opcode constants: OP_LOAD, OP_IMM, OP_REG, OP_LUI;
  - funct3 constants;
  - state enum: IDLE, FETCH, FWAIT, EXEC, LREQ, LWAIT;
  - immediate-extraction functions.
- Sub-module lanzones_regfile provides the register file with x0 hardwired to zero.

Test Plan:
- Reset: rstn=0 for 3 cycles with LEn=0 → RRdy=0, RAddr=0, PC=0, all regs 0, state IDLE. With LEn held 0, no request ever appears.
- LW: mem[0]=32'h01002083 (lw x1,16(x0)), mem[4]=32'hDEADBEEF, LEn raised → expected sequence:
  - fetch request RAddr=0;
  - load request RAddr=4;
  - x1=32'hDEADBEEF;
  - next fetch RAddr=1.
- ADDI+ADD: mem[0]=32'h00100113 (addi x2,x0,1), mem[1]=32'h002101B3 (add x3,x2,x2) → x2=1, x3=2, third fetch at RAddr=2.
- x0 and NOP: mem[0]=32'h01002003 (lw x0,16(x0)) and an unknown opcode at mem[1] → x0 stays 0, PC advances to 8, no extra requests.
- LEn drop: LEn=0 asserted during LWAIT → load completes, state IDLE, PC=4, no RRdy. Re-raising LEn → fetch at RAddr=1.
- Protocol check over 1000 cycles of the LW pattern:
  - RRdy never high on consecutive cycles;
  - RAddr stable from RRdy to RVld;
  - mid-run reset returns to fetch at RAddr=0.
